// File: rtl/fabric_pkg.sv
// fabric_pkg: shared types for registered Loom fabric stages.
//   occ_e       - occupancy of a two-entry skid buffer (empty / one / two)
//   cfg_state_e - configuration state of a stage that must be loaded before use
package fabric_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef enum logic {
        CFG_UNCONFIGURED = 1'b0,
        CFG_CONFIGURED   = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/fabric_skid_buffer.sv
// fabric_skid_buffer: two-entry skid buffer (main + skid register) that
// breaks the valid/ready timing path between producer and consumer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and a source holds its data
// stable while valid is high and ready is low.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   enable_next   - upstream permission to accept tokens from the next cycle
//   in_valid      - token offered
//   in_ready      - registered accept indication (never depends on out_ready)
//   in_data       - token payload
//   out_ready     - downstream accepts the main-register token
//   out_data      - payload of the main register
//   occ           - current occupancy; the consumer-side valid is occ != EMPTY
module fabric_skid_buffer
    import fabric_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_next,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output occ_e             occ
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    occ_e             occ_next;
    logic             push;
    logic             pop;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

    assign push     = in_valid & in_ready;
    assign pop      = (occ != OCC_EMPTY) & out_ready;
    assign out_data = main_q;

    always_comb begin
        occ_next       = occ;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    occ_next  = OCC_ONE;
                    main_load = 1'b1;
                end
            end
            OCC_ONE: begin
                if (push && !pop) begin
                    occ_next  = OCC_TWO;
                    skid_load = 1'b1;
                end else if (push && pop) begin
                    // main is consumed and refilled in the same cycle
                    main_load = 1'b1;
                end else if (pop) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a pop can happen
                if (pop) begin
                    occ_next       = OCC_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: occ_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= OCC_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            occ <= occ_next;
            if (main_load) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= in_data;
            end
            // Registered ready: looks ahead at the occupancy we are moving to
            in_ready <= enable_next & (occ_next != OCC_TWO);
        end
    end

endmodule

// File: rtl/fabric_add_tag.sv
// fabric_add_tag: prepends a runtime-configured tag to untagged stream data.
// Inverse of the fabric tag-strip stage: out_data = {tag, value}, with the
// value in [DATA_WIDTH-1:0] so stripping the tag recovers it bit-exactly.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and a source holds its data
// stable while valid is high and ready is low.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   cfg_valid/ready/data - tag load interface (cfg_ready is registered)
//   in_valid/ready/data  - untagged input stream (in_ready is registered)
//   out_valid/ready/data - tagged output stream from the skid buffer
//
// No token is accepted until the first tag has been loaded. Each token takes
// the tag held in tag_reg during its accept cycle; the tag travels with the
// token through the buffer, so a later tag load never alters queued tokens.
module fabric_add_tag
    import fabric_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int TAG_WIDTH    = 4,
    localparam int IN_PW        = DATA_WIDTH,
    localparam int OUT_PW       = DATA_WIDTH + TAG_WIDTH,
    localparam int CONFIG_WIDTH = TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_PW-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_PW-1:0]       out_data
);

    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $fatal(1, "COMP_ADD_TAG_DATA_WIDTH");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $fatal(1, "COMP_ADD_TAG_TAG_WIDTH");
    end

    cfg_state_e              cfg_state;
    cfg_state_e              cfg_state_next;
    logic [CONFIG_WIDTH-1:0] tag_reg;
    logic                    cfg_fire;
    occ_e                    buf_occ;

    assign cfg_fire = cfg_valid & cfg_ready;

    always_comb begin
        cfg_state_next = cfg_state;
        if (cfg_fire) begin
            cfg_state_next = CFG_CONFIGURED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state <= CFG_UNCONFIGURED;
            cfg_ready <= 1'b0;
            tag_reg   <= '0;
        end else begin
            cfg_state <= cfg_state_next;
            cfg_ready <= 1'b1;
            if (cfg_fire) begin
                tag_reg <= cfg_data;
            end
        end
    end

    // Passing the next config state lets in_ready rise on the same edge that
    // loads the first tag, so data can be accepted in the following cycle.
    fabric_skid_buffer #(
        .WIDTH (OUT_PW)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_next (cfg_state_next == CFG_CONFIGURED),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     ({tag_reg, in_data}),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occ         (buf_occ)
    );

    assign out_valid = (buf_occ != OCC_EMPTY);

endmodule

// File: tb/tb_fabric_add_tag.sv
// Directed bench for fabric_add_tag (DATA_WIDTH=32, TAG_WIDTH=4).
module tb_fabric_add_tag;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = DW + TW;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [TW-1:0] cfg_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    fabric_add_tag #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [OW-1:0] exp_q[$];
    logic [TW-1:0] cur_tag;
    int            pass_count;
    int            fail_count;
    int            total_count;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: score handshakes seen before the edge, then advance to
    // 1 time unit after the edge, where registered outputs are sampled.
    task automatic cycle(output bit pushed);
        pushed = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
        if (pushed) exp_q.push_back({cur_tag, in_data});
        if (cfg_valid && cfg_ready) cur_tag = cfg_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [TW-1:0] tag);
        bit p;
        cfg_valid = 1'b1;
        cfg_data  = tag;
        cycle(p);
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit p;
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 20) begin
            cycle(p);
            n++;
        end
        check({name, "_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        bit p;
        int next_tok;
        int k;

        pass_count = 0;
        fail_count = 0;
        total_count = 0;
        cur_tag   = '0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cfg_ready_rise", 64'(cfg_ready), 64'd1);

        // unconfigured: nothing accepted
        in_valid = 1'b1;
        in_data  = 32'h1234;
        for (int i = 0; i < 10; i++) begin
            cycle(p);
            check("unconf_in_ready",  64'(in_ready),  64'd0);
            check("unconf_out_valid", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;

        // basic tag
        do_cfg(4'h5);
        check("basic_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        cycle(p);
        in_valid = 1'b0;
        check("basic_out_valid", 64'(out_valid), 64'd1);
        check("basic_out_data",  64'(out_data),  64'h5_DEAD_BEEF);
        out_ready = 1'b1;
        cycle(p);
        check("basic_popped", 64'(out_valid), 64'd0);

        // backpressure: only two accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd1;
        cycle(p);
        check("bp_accept1", 64'(p), 64'd1);
        in_data = 32'd2;
        cycle(p);
        check("bp_accept2", 64'(p), 64'd1);
        in_data = 32'd3;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_data", 64'(out_data), 64'h5_0000_0001);
        for (int i = 0; i < 3; i++) begin
            cycle(p);
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            check("bp_hold_data",  64'(out_data), 64'h5_0000_0001);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(p);
            if (p) in_data = in_data + 32'd1;
            check("bp_no_gap", 64'(out_valid), 64'd1);
        end
        drain("bp_drain");

        // tag change mid-stream
        do_cfg(4'h3);
        next_tok = 0;
        k = 0;
        while (next_tok < 10 && k < 80) begin
            out_ready = (k % 2 == 1);
            in_valid  = 1'b1;
            in_data   = 32'(next_tok);
            cfg_data  = 4'hA;
            cfg_valid = (next_tok == 4) && in_ready;
            cycle(p);
            if (p) next_tok++;
            k++;
        end
        cfg_valid = 1'b0;
        check("tagchg_sent", 64'(next_tok), 64'd10);
        check("tagchg_queued", 64'(exp_q.size() > 0), 64'd1);
        drain("tagchg_drain");

        // reset while holding two tokens
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA1;
        cycle(p);
        in_data = 32'hA2;
        cycle(p);
        in_valid = 1'b0;
        check("two_in_ready",  64'(in_ready),  64'd0);
        check("two_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd0);
        check("arst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("arst_out_data",  64'(out_data),  64'd0);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        cur_tag  = '0;
        in_valid = 1'b1;
        in_data  = 32'h55;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(p);
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
            check("post_rst_in_ready",  64'(in_ready),  64'd0);
        end
        check("post_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        in_valid = 1'b0;

        // throughput: 100 back-to-back tokens
        do_cfg(4'hC);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'(i) + 32'h100;
            cycle(p);
            check("tput_accept", 64'(p), 64'd1);
            check("tput_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        cycle(p);
        check("tput_done_valid", 64'(out_valid), 64'd0);
        check("tput_done_left",  64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/fabric_add_tag.md
# fabric_add_tag

Tag-attach module for the Loom fabric: takes untagged streaming data, prepends a runtime-configured tag, and emits tagged data. It is the inverse of the fabric tag-strip module. Output packing is chosen so that stripping the tag recovers the original value bit-exactly. Unlike the strip module, it is registered: a two-entry skid buffer breaks the valid/ready timing path, and a small config interface loads the tag value.

## Interface
Parameters:
- DATA_WIDTH, 32, value width; must be >= 1, else fatal `COMP_ADD_TAG_DATA_WIDTH`.
- TAG_WIDTH, 4, tag width; must be >= 1, else fatal `COMP_ADD_TAG_TAG_WIDTH`.
- IN_PW (localparam), DATA_WIDTH, input payload width.
- OUT_PW (localparam), DATA_WIDTH+TAG_WIDTH, output payload width.
- CONFIG_WIDTH (localparam), TAG_WIDTH, config payload width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  config word offered.
- cfg_ready  output  1  config accepted when high together with cfg_valid.
- cfg_data  input  TAG_WIDTH  new tag value.
- in_valid  input  1  untagged token offered.
- in_ready  output  1  token accepted when high together with in_valid.
- in_data  input  IN_PW  untagged value.
- out_valid  output  1  tagged token available.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_PW  {tag, value}; value sits in [DATA_WIDTH-1:0], tag sits in [OUT_PW-1:DATA_WIDTH].

## Operation
- Config FSM: UNCONFIGURED -> CONFIGURED on the first cfg handshake. Only reset returns it to UNCONFIGURED.
- While UNCONFIGURED, in_ready = 0, so no data is accepted.
- cfg_ready is a register: it is 0 in reset and 1 from the first clk edge after rst_n rises.
- A cfg handshake writes tag_reg at that edge.
- Tag capture: each token latches the tag_reg value current in its accept cycle, and the tag is stored in the buffer alongside the data.
  - A token accepted in the same cycle as a cfg handshake gets the old tag.
  - Tokens accepted from the next cycle onward get the new tag.
  - Buffered tokens never change tag.
- Skid buffer with states EMPTY, ONE, TWO (main register plus skid register). Notation: push = in_valid & in_ready; pop = out_valid & out_ready.
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO; !push & pop -> EMPTY; push & pop -> ONE (main reloads).
  - TWO: pop -> ONE (skid moves to main). Push is impossible in TWO because in_ready = 0.
- out_valid = (state != EMPTY). out_data always comes from the main register.
- in_ready is registered and equals CONFIGURED & (next_state != TWO). It never combinationally depends on out_ready.
- Ordering is strict FIFO: no loss, no duplication.
- out_data is held stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, in_ready = 0, cfg_ready = 0, tag_reg = 0, state EMPTY/UNCONFIGURED.
- Reset asserts asynchronously; outputs go to their reset values immediately. Buffered tokens and config are discarded.
- Latency: a token accepted at edge N is presented with out_valid high after edge N, i.e. one cycle.
- Throughput: with out_ready held at 1, one token per cycle sustained.
- Earliest data accept: the cycle after the cfg handshake, because in_ready rises on the edge that loads tag_reg.
- Backpressure: with out_ready = 0, exactly two tokens are accepted. in_ready falls in the cycle after the second accept.
- Simultaneous cfg handshake and data push are legal; the tag rule above applies.

## Structure
- Shared package fabric_pkg: occupancy enum (EMPTY/ONE/TWO) and the config-state enum, reusable by other registered fabric stages.
- Sub-module fabric_skid_buffer, parameterised by width and carrying {tag, data} as one payload. fabric_add_tag holds the config FSM, tag_reg, packing and parameter checks.

## Test plan
- Unconfigured block: after reset, in_valid = 1 with in_data = 0x1234 for 10 cycles -> in_ready = 0 and out_valid = 0 throughout.
- Basic tag: cfg 0x5, then in_data = 0xDEADBEEF -> next cycle out_data = 0x5DEADBEEF, out_valid = 1.
- Backpressure: out_ready = 0, continuous input 1, 2, 3... -> only 1 and 2 accepted, and in_ready low from the cycle after 2 is accepted. Then out_ready = 1 -> output 1, 2, 3... in order, with no gap once flow resumes.
- Tag change mid-stream: tag 0x3, stream 0..9, cfg 0xA in the cycle token 4 is accepted -> tokens 0..4 carry 0x3, tokens 5..9 carry 0xA, including tokens still buffered at the change.
- Reset mid-operation: in state TWO, pulse rst_n low between edges -> out_valid, in_ready and cfg_ready drop at once. After release, no stale token appears and the block is UNCONFIGURED again.
- Throughput: out_ready = 1 and 100 back-to-back tokens -> 100 outputs in 100 consecutive cycles, first output one cycle after the first accept.
